// File: rtl/rob_pkg.sv
// rob_pkg: shared ROB/RS types (tag_t, rv32i_word, alu_cdb_t, rob_out_t), sizes and pointer wrap helper
package rob_pkg;
  localparam int NUM_ROB = 8;
  localparam int NUM_ALU_RS = 5;
  typedef logic [31:0] rv32i_word;
  typedef logic [$clog2(NUM_ROB+1)-1:0] tag_t;
  typedef logic [$clog2(NUM_ROB)-1:0] ptr_t;
  typedef logic [$clog2(NUM_ROB+1)-1:0] cnt_t;
  typedef struct packed {
    logic [NUM_ALU_RS-1:0] valid;
    tag_t [NUM_ALU_RS-1:0] tags;
    rv32i_word [NUM_ALU_RS-1:0] vals;
  } alu_cdb_t;
  typedef struct packed {
    logic [NUM_ROB:0] ready;
    rv32i_word [NUM_ROB:0] vals;
  } rob_out_t;
  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(NUM_ROB - 1)) ? '0 : p + 1'b1;
  endfunction
endpackage

// File: rtl/rob_if.sv
// rob_if: ROB bundle; master = decoder/CDB/regfile side (flush, alloc_*, alu_res in), slave = rob (alloc_ready/tag, rob_data, commit_* out)
interface rob_if;
  import rob_pkg::*;
  logic flush;
  logic alloc_valid;
  logic [4:0] alloc_rd;
  logic alloc_ready;
  tag_t alloc_tag;
  alu_cdb_t alu_res;
  rob_out_t rob_data;
  logic commit_valid;
  logic [4:0] commit_rd;
  rv32i_word commit_val;
  tag_t commit_tag;
  modport master (
    output flush, alloc_valid, alloc_rd, alu_res,
    input alloc_ready, alloc_tag, rob_data, commit_valid, commit_rd, commit_val, commit_tag
  );
  modport slave (
    input flush, alloc_valid, alloc_rd, alu_res,
    output alloc_ready, alloc_tag, rob_data, commit_valid, commit_rd, commit_val, commit_tag
  );
endinterface

// File: rtl/rob.sv
// rob: reorder buffer; ports clk, rst (async high), io (rob_if.slave: flush, alloc, CDB capture, per-tag ready/vals, in-order commit)
module rob
  import rob_pkg::*;
(
  input logic clk,
  input logic rst,
  rob_if.slave io
);
  logic [NUM_ROB-1:0] busy, rdy;
  logic [NUM_ROB-1:0][4:0] rd;
  rv32i_word [NUM_ROB-1:0] val;
  ptr_t head, tail;
  cnt_t cnt;
  logic do_alloc, do_commit;
  logic [NUM_ROB-1:0] wb_hit;
  rv32i_word [NUM_ROB-1:0] wb_val;
  assign io.alloc_ready = cnt < cnt_t'(NUM_ROB);
  assign io.alloc_tag = tag_t'(tail) + 1'b1;
  assign io.commit_valid = busy[head] && rdy[head];
  assign io.commit_rd = rd[head];
  assign io.commit_val = val[head];
  assign io.commit_tag = tag_t'(head) + 1'b1;
  assign io.rob_data = '{ready: {rdy, 1'b0}, vals: {val, rv32i_word'(0)}};
  assign do_alloc = io.alloc_valid && io.alloc_ready;
  assign do_commit = io.commit_valid;
  always_comb begin
    wb_hit = '0;
    wb_val = '0;
    for (int e = 0; e < NUM_ROB; e++)
      for (int i = NUM_ALU_RS - 1; i >= 0; i--)
        if (io.alu_res.valid[i] && io.alu_res.tags[i] == tag_t'(e + 1)) begin
          wb_hit[e] = 1'b1;
          wb_val[e] = io.alu_res.vals[i];
        end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      rdy <= '0;
      rd <= '0;
      val <= '0;
      head <= '0;
      tail <= '0;
      cnt <= '0;
    end else if (io.flush) begin
      busy <= '0;
      rdy <= '0;
      head <= '0;
      tail <= '0;
      cnt <= '0;
    end else begin
      for (int e = 0; e < NUM_ROB; e++)
        if (wb_hit[e] && busy[e] && !rdy[e]) begin
          rdy[e] <= 1'b1;
          val[e] <= wb_val[e];
        end
      if (do_commit) begin
        busy[head] <= 1'b0;
        head <= ptr_inc(head);
      end
      if (do_alloc) begin
        busy[tail] <= 1'b1;
        rdy[tail] <= 1'b0;
        rd[tail] <= io.alloc_rd;
        val[tail] <= '0;
        tail <= ptr_inc(tail);
      end
      cnt <= cnt + cnt_t'(do_alloc) - cnt_t'(do_commit);
    end
  end
endmodule
